gray_sync_debounce: RTL and testbench
=====================================

# gray_sync_debounce

Parametrised synchroniser and debouncer for Gray-coded switch inputs. It passes an asynchronous WIDTH-bit switch bus through a STAGES-deep synchroniser, then accepts a new value only after it has been stable for DEBOUNCE_CYCLES samples. Each committed value produces a one-cycle change pulse. An optional checker flags any committed transition that is not a single-bit Gray step. It sits between the board switches and the Gray decoder datapath.

## Interface
- WIDTH, 4, switch/Gray bus width (≥1)
- STAGES, 2, synchroniser flop count (≥2)
- DEBOUNCE_CYCLES, 4, consecutive equal samples required to commit (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- read  in  1  sample enable; when 0 all state holds
- gray_switch  in  WIDTH  raw asynchronous switch bus
- gray_in  out  WIDTH  committed, debounced Gray value
- changed  out  1  one-cycle pulse, high in the cycle gray_in shows a new value
- gray_err  out  1  sticky flag: a commit differed from the previous value in ≠1 bit

## Operation
- Sync chain: on each clk edge with read=1, stage[0]<=gray_switch and stage[i]<=stage[i-1]. s = stage[STAGES-1].
- Debounce state: cand (WIDTH), cnt (width $clog2(DEBOUNCE_CYCLES+1)), saturating at DEBOUNCE_CYCLES.
- Each edge with read=1, evaluated in this order:
  - If s≠cand: cand<=s, cnt<=1, no commit.
  - Else if cnt<DEBOUNCE_CYCLES: cnt<=cnt+1.
  - Else if cnt==DEBOUNCE_CYCLES and cand≠gray_in: commit, i.e. gray_in<=cand and changed<=1.
- changed<=0 on every edge that does not commit, including all edges with read=0.
- A glitch shorter than DEBOUNCE_CYCLES samples reloads cand and never commits.
- A return to the already committed value commits nothing.
- read=0: sync chain, cand, cnt, gray_in and gray_err hold; changed is 0.

## Timing
- Reset (async assert, sync release by the system): every stage, cand, cnt, gray_in, changed and gray_err are 0.
- Latency: a value V stable at gray_switch from the edge that first samples it, with read held 1, appears on gray_in STAGES+DEBOUNCE_CYCLES+1 edges later (7 with defaults). changed is high in that same cycle only.
- Stalled read cycles add one cycle of latency each.
- Reset asserted mid-debounce discards cand/cnt. The first post-reset value is compared against gray_in=0.
- Back-to-back commits are separated by at least DEBOUNCE_CYCLES+1 enabled edges.

## Configuration
- GRAY_CHECK_EN defined: on each commit, if popcount(cand ^ gray_in)≠1 then gray_err<=1. The flag stays set until rst.
- GRAY_CHECK_EN undefined: checker logic is absent and gray_err is tied to 0. The port remains.

## Structure
- Package gray_pkg:
  - default constants GRAY_WIDTH=4, SYNC_STAGES=2, DEBOUNCE_DEFAULT=4
  - function is_single_bit_step(a,b) returning popcount(a^b)==1
- Sub-module sync_chain (WIDTH, STAGES, enable) holds the flop chain. gray_sync_debounce instantiates it and owns the debounce/commit/check logic.

## Test plan
- Reset then hold gray_switch=4'b0000, read=1 for 20 cycles -> gray_in=0, changed never pulses, gray_err=0.
- Step 0000->0001, read=1 -> gray_in=0001 exactly 7 edges after first sampling, changed high for 1 cycle, gray_err=0.
- 0001->0011 glitch lasting 3 cycles, then back to 0001 -> no commit, gray_in stays 0001, changed stays 0.
- 0001->0110 (3-bit jump) held stable -> commits 0110 after 7 edges. gray_err=1 with GRAY_CHECK_EN, stays 0 without it. After rst, gray_err=0.
- Step to 0011 with read toggling 1/0 each cycle -> commit after 7 enabled edges (14 cycles), changed still a single cycle.
- Assert rst mid-debounce of 0010 -> all outputs 0 immediately. After release with 0010 still applied, commit occurs 7 edges later.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and the Gray single-step helper for the switch
// synchroniser/debouncer.
package gray_pkg;

    localparam int GRAY_WIDTH       = 4;
    localparam int SYNC_STAGES      = 2;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int STEP_MAX_WIDTH   = 64;

    // Callers zero-extend narrower buses to STEP_MAX_WIDTH before calling.
    function automatic logic is_single_bit_step(
        input logic [STEP_MAX_WIDTH-1:0] a,
        input logic [STEP_MAX_WIDTH-1:0] b
    );
        logic [STEP_MAX_WIDTH-1:0] diff;
        int unsigned               ones;
        diff = a ^ b;
        ones = 0;
        for (int i = 0; i < STEP_MAX_WIDTH; i++) begin
            ones = ones + {31'd0, diff[i]};
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Enable-gated multi-flop synchroniser for an asynchronous bus.
module sync_chain
    import gray_pkg::*;
#(
    parameter int WIDTH  = GRAY_WIDTH,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES+1];

    assign chain[0] = d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_reg <= '0;
            end else if (enable) begin
                stage_reg <= chain[gi];
            end
        end

        assign chain[gi+1] = stage_reg;
    end

    assign q = chain[STAGES];

endmodule

// File: rtl/gray_sync_debounce.sv
// Synchronises and debounces a Gray-coded switch bus, pulsing changed on each
// commit. Define GRAY_CHECK_EN to build the sticky non-single-step checker.
module gray_sync_debounce
    import gray_pkg::*;
#(
    parameter int WIDTH           = GRAY_WIDTH,
    parameter int STAGES          = SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read,
    input  logic [WIDTH-1:0] gray_switch,
    output logic [WIDTH-1:0] gray_in,
    output logic             changed,
    output logic             gray_err
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand_reg, cand_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] gray_reg, gray_next;
    logic             changed_reg, changed_next;
    logic             commit;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .enable (read),
        .d      (gray_switch),
        .q      (sync_q)
    );

    always_comb begin
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        gray_next    = gray_reg;
        changed_next = 1'b0;
        commit       = 1'b0;
        if (read) begin
            if (sync_q != cand_reg) begin
                cand_next = sync_q;
                cnt_next  = CNT_ONE;
            end else if (cnt_reg < CNT_MAX) begin
                cnt_next = cnt_reg + CNT_ONE;
            end else if (cand_reg != gray_reg) begin
                commit       = 1'b1;
                gray_next    = cand_reg;
                changed_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_reg    <= '0;
            cnt_reg     <= '0;
            gray_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            cand_reg    <= cand_next;
            cnt_reg     <= cnt_next;
            gray_reg    <= gray_next;
            changed_reg <= changed_next;
        end
    end

`ifdef GRAY_CHECK_EN
    logic err_reg, err_next;

    always_comb begin
        err_next = err_reg;
        if (commit && !is_single_bit_step(STEP_MAX_WIDTH'(cand_reg),
                                          STEP_MAX_WIDTH'(gray_reg))) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign gray_err = err_reg;
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign gray_err      = 1'b0;
`endif

    assign gray_in = gray_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_gray_sync_debounce.sv
// Directed bench for gray_sync_debounce with default parameters.
module tb_gray_sync_debounce;

`ifdef GRAY_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       read;
    logic [3:0] gray_switch;
    logic [3:0] gray_in;
    logic       changed;
    logic       gray_err;

    int         n_checks;
    int         n_errors;
    logic [3:0] exp_gray;

    gray_sync_debounce dut (
        .clk         (clk),
        .rst         (rst),
        .read        (read),
        .gray_switch (gray_switch),
        .gray_in     (gray_in),
        .changed     (changed),
        .gray_err    (gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies v with read=1 and checks the commit lands exactly on the 7th edge.
    task automatic expect_commit(input string tag, input logic [3:0] v);
        logic early;
        early = 1'b0;
        gray_switch = v;
        read = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (gray_in !== exp_gray || changed !== 1'b0) early = 1'b1;
        end
        check_val({tag, "_early"}, {31'd0, early}, 32'd0);
        tick();
        check_val({tag, "_gray"}, {28'd0, gray_in}, {28'd0, v});
        check_val({tag, "_pulse"}, {31'd0, changed}, 32'd1);
        tick();
        check_val({tag, "_pulse_end"}, {31'd0, changed}, 32'd0);
        check_val({tag, "_hold"}, {28'd0, gray_in}, {28'd0, v});
        exp_gray = v;
        $display("commit %s: %b -> gray_in %b", tag, v, gray_in);
    endtask

    initial begin
        int   seen_change;
        int   en_edges;
        int   commit_edge;
        int   pulses;
        logic moved;

        n_checks    = 0;
        n_errors    = 0;
        exp_gray    = 4'b0000;
        rst         = 1'b1;
        read        = 1'b1;
        gray_switch = 4'b0000;

        repeat (2) tick();
        check_val("rst_gray", {28'd0, gray_in}, 32'd0);
        check_val("rst_changed", {31'd0, changed}, 32'd0);
        check_val("rst_err", {31'd0, gray_err}, 32'd0);
        rst = 1'b0;
        $display("reset: gray_in %b changed %b err %b", gray_in, changed, gray_err);

        seen_change = 0;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (changed) seen_change++;
            if (gray_in !== 4'b0000) moved = 1'b1;
        end
        check_val("idle_gray", {31'd0, moved}, 32'd0);
        check_val("idle_changed", seen_change, 0);
        check_val("idle_err", {31'd0, gray_err}, 32'd0);
        $display("idle: 20 cycles, %0d pulses", seen_change);

        expect_commit("step1", 4'b0001);
        check_val("step1_err", {31'd0, gray_err}, 32'd0);

        gray_switch = 4'b0011;
        seen_change = 0;
        moved = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) gray_switch = 4'b0001;
            tick();
            if (changed) seen_change++;
            if (gray_in !== 4'b0001) moved = 1'b1;
        end
        check_val("glitch_gray", {31'd0, moved}, 32'd0);
        check_val("glitch_changed", seen_change, 0);
        $display("glitch: 3-cycle 0011, %0d pulses, gray_in %b", seen_change, gray_in);

        expect_commit("jump", 4'b0110);
        check_val("jump_err", {31'd0, gray_err}, {31'd0, CHK});

        gray_switch = 4'b0000;
        rst = 1'b1;
        #1;
        check_val("rst2_err", {31'd0, gray_err}, 32'd0);
        check_val("rst2_gray", {28'd0, gray_in}, 32'd0);
        tick();
        rst = 1'b0;
        exp_gray = 4'b0000;
        $display("reset after jump: err %b", gray_err);

        gray_switch = 4'b0011;
        en_edges = 0;
        commit_edge = 0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            read = (i % 2 == 0);
            tick();
            if (read) en_edges++;
            if (changed) pulses++;
            if (gray_in === 4'b0011 && commit_edge == 0) commit_edge = en_edges;
        end
        read = 1'b1;
        check_val("stall_edge", commit_edge, 7);
        check_val("stall_pulses", pulses, 1);
        check_val("stall_gray", {28'd0, gray_in}, 32'h3);
        check_val("stall_err", {31'd0, gray_err}, {31'd0, CHK});
        exp_gray = 4'b0011;
        $display("stall: commit on enabled edge %0d, %0d pulses", commit_edge, pulses);

        gray_switch = 4'b0010;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_val("rst3_gray", {28'd0, gray_in}, 32'd0);
        check_val("rst3_changed", {31'd0, changed}, 32'd0);
        check_val("rst3_err", {31'd0, gray_err}, 32'd0);
        tick();
        rst = 1'b0;
        exp_gray = 4'b0000;
        $display("reset mid-debounce: gray_in %b", gray_in);
        expect_commit("post_rst", 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
